// File: rtl/tetris_input_pkg.sv
// Shared types and helpers for the tetris input conditioner.
// The joystick zone encoding is also read by tetris_grid.
package tetris_input_pkg;

    typedef enum logic [1:0] {
        ZONE_CENTER = 2'd0,
        ZONE_LEFT   = 2'd1,
        ZONE_RIGHT  = 2'd2
    } zone_t;

    // Bits needed to hold 0..max_val; never returns 0 so counters stay legal.
    function automatic int unsigned cnt_width(input int unsigned max_val);
        int unsigned w;
        w = 32'd1;
        if (max_val > 32'd1) begin
            w = $clog2(max_val + 32'd1);
        end else begin
            w = 32'd1;
        end
        return w;
    endfunction

endpackage

// File: rtl/tetris_debounce.sv
// One pushbutton: 2-flop synchroniser, polarity normalise, debounce counter
// and a registered press pulse on the debounced 0->1 transition.
module tetris_debounce
    import tetris_input_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYC = 32'd500_000,
    parameter bit          BTN_ACT_LOW  = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic press_en,
    input  logic btn_raw,
    output logic btn_level,
    output logic btn_press
);

    localparam int unsigned CNT_MAX = (DEBOUNCE_CYC > 32'd0) ? DEBOUNCE_CYC - 32'd1 : 32'd0;
    localparam int unsigned CNT_W   = cnt_width(CNT_MAX);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CNT_MAX);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(32'd1);
    localparam logic RELEASED_RAW = BTN_ACT_LOW;

    logic             sync1_r;
    logic             sync2_r;
    logic [CNT_W-1:0] cnt_r;
    logic             level_r;
    logic             press_r;
    logic             pressed_s;
    logic [CNT_W-1:0] cnt_nxt_s;
    logic             level_nxt_s;
    logic             press_nxt_s;

    assign pressed_s = sync2_r ^ RELEASED_RAW;

    // Debounce: count disagreeing cycles, toggle the level on the last one
    always_comb begin
        cnt_nxt_s   = '0;
        level_nxt_s = level_r;
        press_nxt_s = 1'b0;
        if (pressed_s != level_r) begin
            if (cnt_r == CNT_LAST) begin
                level_nxt_s = pressed_s;
                press_nxt_s = pressed_s & press_en;
            end else begin
                cnt_nxt_s = cnt_r + CNT_ONE;
            end
        end else begin
            cnt_nxt_s = '0;
        end
    end

    // Synchroniser and debounce state; sync flops reset to the released level
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_r <= RELEASED_RAW;
            sync2_r <= RELEASED_RAW;
            cnt_r   <= '0;
            level_r <= 1'b0;
            press_r <= 1'b0;
        end else begin
            sync1_r <= btn_raw;
            sync2_r <= sync1_r;
            cnt_r   <= cnt_nxt_s;
            level_r <= level_nxt_s;
            press_r <= press_nxt_s;
        end
    end

    assign btn_level = level_r;
    assign btn_press = press_r;

endmodule

// File: rtl/tetris_input_ctrl.sv
// Input conditioner for tetris_grid: hysteretic joystick zone FSM with DAS/ARR
// move pulses, per-button debounce and an all-buttons-held combo pulse.
module tetris_input_ctrl
    import tetris_input_pkg::*;
#(
    parameter int unsigned ADC_W        = 32'd12,
    parameter int unsigned NUM_BTN      = 32'd2,
    parameter bit          BTN_ACT_LOW  = 1'b1,
    parameter int unsigned DEBOUNCE_CYC = 32'd500_000,
    parameter int          THRESH_HI    = 32'sd1900,
    parameter int          THRESH_LO    = 32'sd1400,
    parameter int          HYST         = 32'sd50,
    parameter int unsigned DAS_CYC      = 32'd8_333_333,
    parameter int unsigned ARR_CYC      = 32'd2_500_000,
    parameter int unsigned COMBO_CYC    = 32'd50_000_000
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               enable,
    input  logic [ADC_W-1:0]   adc_value,
    input  logic               adc_valid,
    input  logic [NUM_BTN-1:0] btn_raw,
    output logic [NUM_BTN-1:0] btn_level,
    output logic [NUM_BTN-1:0] btn_press,
    output logic               move_left,
    output logic               move_right,
    output zone_t              zone,
    output logic               combo_pulse
);

    if (!(THRESH_LO + HYST < THRESH_HI - HYST)) begin : g_bad_thresh
        $error("tetris_input_ctrl: hysteresis bands overlap (THRESH_LO+HYST >= THRESH_HI-HYST)");
    end

    localparam logic [ADC_W-1:0] ENTER_R = ADC_W'(THRESH_HI);
    localparam logic [ADC_W-1:0] ENTER_L = ADC_W'(THRESH_LO);
    localparam logic [ADC_W-1:0] EXIT_R  = ADC_W'(THRESH_HI - HYST);
    localparam logic [ADC_W-1:0] EXIT_L  = ADC_W'(THRESH_LO + HYST);

    localparam int unsigned TMR_MAX = (DAS_CYC > ARR_CYC) ? DAS_CYC : ARR_CYC;
    localparam int unsigned TMR_W   = cnt_width(TMR_MAX);
    localparam logic [TMR_W-1:0] TMR_ONE = TMR_W'(32'd1);
    localparam logic [TMR_W-1:0] DAS_LD  = TMR_W'(DAS_CYC);
    localparam logic [TMR_W-1:0] ARR_LD  = TMR_W'(ARR_CYC);

    localparam int unsigned CMB_MAX = (COMBO_CYC > 32'd0) ? COMBO_CYC - 32'd1 : 32'd0;
    localparam int unsigned CMB_W   = cnt_width(CMB_MAX);
    localparam logic [CMB_W-1:0] CMB_LAST = CMB_W'(CMB_MAX);
    localparam logic [CMB_W-1:0] CMB_ONE  = CMB_W'(32'd1);

    zone_t            zone_r;
    zone_t            zone_nxt_s;
    zone_t            target_s;
    logic [TMR_W-1:0] timer_r;
    logic [TMR_W-1:0] timer_nxt_s;
    logic             move_left_r;
    logic             move_right_r;
    logic             left_nxt_s;
    logic             right_nxt_s;

    logic [CMB_W-1:0] combo_cnt_r;
    logic [CMB_W-1:0] combo_cnt_nxt_s;
    logic             armed_r;
    logic             armed_nxt_s;
    logic             combo_r;
    logic             combo_nxt_s;
    logic             all_held_s;
    logic             none_held_s;

    for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
        tetris_debounce #(
            .DEBOUNCE_CYC (DEBOUNCE_CYC),
            .BTN_ACT_LOW  (BTN_ACT_LOW)
        ) u_debounce (
            .clk       (clk),
            .reset     (reset),
            .press_en  (enable),
            .btn_raw   (btn_raw[i]),
            .btn_level (btn_level[i]),
            .btn_press (btn_press[i])
        );
    end

    // Hysteretic zone the current sample points to (applied only on adc_valid)
    always_comb begin
        target_s = zone_r;
        case (zone_r)
            ZONE_CENTER: begin
                if (adc_value > ENTER_R) begin
                    target_s = ZONE_RIGHT;
                end else if (adc_value < ENTER_L) begin
                    target_s = ZONE_LEFT;
                end else begin
                    target_s = ZONE_CENTER;
                end
            end
            ZONE_RIGHT: begin
                if (adc_value < ENTER_L) begin
                    target_s = ZONE_LEFT;
                end else if (adc_value <= EXIT_R) begin
                    target_s = ZONE_CENTER;
                end else begin
                    target_s = ZONE_RIGHT;
                end
            end
            ZONE_LEFT: begin
                if (adc_value > ENTER_R) begin
                    target_s = ZONE_RIGHT;
                end else if (adc_value >= EXIT_L) begin
                    target_s = ZONE_CENTER;
                end else begin
                    target_s = ZONE_LEFT;
                end
            end
            default: target_s = ZONE_CENTER;
        endcase
    end

    // Zone transitions and DAS/ARR timer; a zone change outranks a timer expiry
    always_comb begin
        zone_nxt_s  = zone_r;
        timer_nxt_s = timer_r;
        left_nxt_s  = 1'b0;
        right_nxt_s = 1'b0;
        if (!enable) begin
            zone_nxt_s  = ZONE_CENTER;
            timer_nxt_s = '0;
        end else if (adc_valid && (target_s != zone_r)) begin
            zone_nxt_s = target_s;
            case (target_s)
                ZONE_LEFT: begin
                    left_nxt_s  = 1'b1;
                    timer_nxt_s = DAS_LD;
                end
                ZONE_RIGHT: begin
                    right_nxt_s = 1'b1;
                    timer_nxt_s = DAS_LD;
                end
                default: timer_nxt_s = '0;
            endcase
        end else if ((zone_r != ZONE_CENTER) && (timer_r == TMR_ONE)) begin
            left_nxt_s  = (zone_r == ZONE_LEFT);
            right_nxt_s = (zone_r == ZONE_RIGHT);
            timer_nxt_s = ARR_LD;
        end else if (timer_r != '0) begin
            timer_nxt_s = timer_r - TMR_ONE;
        end else begin
            timer_nxt_s = '0;
        end
    end

    // Combo: saturating hold counter, one pulse per full release/press cycle
    always_comb begin
        all_held_s      = &btn_level;
        none_held_s     = ~|btn_level;
        combo_cnt_nxt_s = '0;
        armed_nxt_s     = armed_r;
        combo_nxt_s     = 1'b0;
        if (all_held_s) begin
            if (combo_cnt_r == CMB_LAST) begin
                combo_cnt_nxt_s = combo_cnt_r;
                if (armed_r) begin
                    combo_nxt_s = enable;
                    armed_nxt_s = 1'b0;
                end else begin
                    armed_nxt_s = armed_r;
                end
            end else begin
                combo_cnt_nxt_s = combo_cnt_r + CMB_ONE;
            end
        end else begin
            combo_cnt_nxt_s = '0;
            if (none_held_s) begin
                armed_nxt_s = 1'b1;
            end else begin
                armed_nxt_s = armed_r;
            end
        end
    end

    // Zone FSM, repeat timer and move pulse registers
    always_ff @(posedge clk) begin
        if (reset) begin
            zone_r       <= ZONE_CENTER;
            timer_r      <= '0;
            move_left_r  <= 1'b0;
            move_right_r <= 1'b0;
        end else begin
            zone_r       <= zone_nxt_s;
            timer_r      <= timer_nxt_s;
            move_left_r  <= left_nxt_s;
            move_right_r <= right_nxt_s;
        end
    end

    // Combo counter, re-arm flag and pulse register
    always_ff @(posedge clk) begin
        if (reset) begin
            combo_cnt_r <= '0;
            armed_r     <= 1'b1;
            combo_r     <= 1'b0;
        end else begin
            combo_cnt_r <= combo_cnt_nxt_s;
            armed_r     <= armed_nxt_s;
            combo_r     <= combo_nxt_s;
        end
    end

    assign zone        = zone_r;
    assign move_left   = move_left_r;
    assign move_right  = move_right_r;
    assign combo_pulse = combo_r;

endmodule

// File: tb/tb_tetris_input_ctrl.sv
// Self-checking bench for tetris_input_ctrl: event-level reference model compared
// every cycle, directed scenarios pinned with literal expectations, then random stimulus.
module tb_tetris_input_ctrl;

    localparam int NB    = 2;
    localparam int DEB   = 4;
    localparam int DAS   = 10;
    localparam int ARR   = 3;
    localparam int COMBO = 20;
    localparam int TH_HI = 1900;
    localparam int TH_LO = 1400;
    localparam int HYST  = 50;

    logic          clk = 1'b0;
    logic          reset;
    logic          enable;
    logic [11:0]   adc_value;
    logic          adc_valid;
    logic [NB-1:0] btn_raw;
    logic [NB-1:0] btn_level;
    logic [NB-1:0] btn_press;
    logic          move_left;
    logic          move_right;
    logic [1:0]    zone;
    logic          combo_pulse;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    always #5 clk = ~clk;

    tetris_input_ctrl #(
        .ADC_W(12), .NUM_BTN(NB), .BTN_ACT_LOW(1'b1), .DEBOUNCE_CYC(DEB),
        .THRESH_HI(TH_HI), .THRESH_LO(TH_LO), .HYST(HYST),
        .DAS_CYC(DAS), .ARR_CYC(ARR), .COMBO_CYC(COMBO)
    ) dut (
        .clk(clk), .reset(reset), .enable(enable), .adc_value(adc_value),
        .adc_valid(adc_valid), .btn_raw(btn_raw), .btn_level(btn_level),
        .btn_press(btn_press), .move_left(move_left), .move_right(move_right),
        .zone(zone), .combo_pulse(combo_pulse)
    );

    // ---------------- reference model (state after each clock edge) ----------------
    int            m_edge = 0;
    logic [NB-1:0] m_s1, m_s2, m_lvl, m_press;
    int            m_run [NB];
    int            m_zone;       // 0 center, 1 left, 2 right
    logic          m_ml, m_mr;
    int            m_next_rep;   // edge index of the next repeat pulse, -1 = none
    int            m_hold;       // consecutive edges with every button held
    logic          m_armed, m_combo;

    function automatic int target_zone(input int cur, input int v);
        if (cur == 0) return (v > TH_HI) ? 2 : ((v < TH_LO) ? 1 : 0);
        if (cur == 2) return (v < TH_LO) ? 1 : ((v <= TH_HI - HYST) ? 0 : 2);
        return (v > TH_HI) ? 2 : ((v >= TH_LO + HYST) ? 0 : 1);
    endfunction

    task automatic model_step();
        int nz;
        m_edge++;
        if (reset) begin
            m_s1 = '1; m_s2 = '1; m_lvl = '0; m_press = '0;
            for (int i = 0; i < NB; i++) m_run[i] = 0;
            m_zone = 0; m_ml = 1'b0; m_mr = 1'b0; m_next_rep = -1;
            m_hold = 0; m_armed = 1'b1; m_combo = 1'b0;
        end else begin
            m_combo = 1'b0;
            if (&m_lvl) begin
                m_hold++;
                if (m_hold == COMBO && m_armed) begin
                    m_combo = enable;
                    m_armed = 1'b0;
                end
            end else begin
                m_hold = 0;
                if (m_lvl == '0) m_armed = 1'b1;
            end
            for (int i = 0; i < NB; i++) begin
                logic p;
                p = ~m_s2[i];
                m_press[i] = 1'b0;
                if (p != m_lvl[i]) begin
                    m_run[i]++;
                    if (m_run[i] == DEB) begin
                        m_lvl[i] = p;
                        m_press[i] = p & enable;
                        m_run[i] = 0;
                    end
                end else begin
                    m_run[i] = 0;
                end
                m_s2[i] = m_s1[i];
                m_s1[i] = btn_raw[i];
            end
            m_ml = 1'b0; m_mr = 1'b0;
            if (!enable) begin
                m_zone = 0; m_next_rep = -1;
            end else begin
                nz = adc_valid ? target_zone(m_zone, int'(adc_value)) : m_zone;
                if (nz != m_zone) begin
                    m_zone = nz;
                    m_ml = (nz == 1); m_mr = (nz == 2);
                    m_next_rep = (nz == 0) ? -1 : m_edge + DAS;
                end else if (m_zone != 0 && m_edge == m_next_rep) begin
                    m_ml = (m_zone == 1); m_mr = (m_zone == 2);
                    m_next_rep = m_edge + ARR;
                end
            end
        end
    endtask

    task automatic compare();
        logic [8:0] act, exp;
        act = {btn_level, btn_press, move_left, move_right, zone, combo_pulse};
        exp = {m_lvl, m_press, m_ml, m_mr, 2'(m_zone), m_combo};
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL model_cmp cyc=%0d got lvl/prs/ml/mr/zone/cmb=%b expected %b", cyc, act, exp);
        end
        tests++;
        if ((move_left & move_right) !== 1'b0) begin
            fails++;
            $display("FAIL move_exclusive cyc=%0d got ml=%b mr=%b expected not both", cyc, move_left, move_right);
        end
    endtask

    task automatic check_lit(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s cyc=%0d got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    // Inputs already driven: advance one clock and check the resulting outputs.
    task automatic cycle();
        model_step();
        @(negedge clk);
        cyc++;
        compare();
    endtask

    initial begin
        int obs;
        int cnt;
        int ch;
        reset = 1'b1; enable = 1'b1; adc_value = 12'd2000; adc_valid = 1'b1; btn_raw = 2'b00;

        // Reset with buttons held and stick deflected
        for (int n = 0; n < 3; n++) begin
            cycle();
            check_lit("reset_outputs", {btn_level, btn_press, move_left, move_right, zone, combo_pulse}, 32'd0);
        end

        // Release: hold right, buttons still held -> level at 6, combo at 26
        reset = 1'b0;
        for (int n = 0; n < 30; n++) begin
            cycle();
            obs = n + 1;
            check_lit("rst_level", btn_level, (obs >= 6) ? 32'd3 : 32'd0);
            check_lit("rst_press", btn_press, (obs == 6) ? 32'd3 : 32'd0);
            check_lit("hold_right", move_right, (obs == 1 || (obs >= 11 && (obs - 11) % 3 == 0)) ? 32'd1 : 32'd0);
            check_lit("hold_right_no_left", move_left, 32'd0);
            check_lit("hold_right_zone", zone, 32'd2);
            check_lit("combo_first", combo_pulse, (obs == 26) ? 32'd1 : 32'd0);
        end

        // Hysteresis: 1870 keeps RIGHT, 1850 drops to CENTER with no pulse
        btn_raw = 2'b11;
        adc_value = 12'd1870;
        cnt = 0;
        for (int n = 0; n < 12; n++) begin
            cycle();
            check_lit("hyst_hold_zone", zone, 32'd2);
            cnt += int'(move_right);
        end
        check_lit("hyst_repeats_continue", (cnt >= 3) ? 32'd1 : 32'd0, 32'd1);
        adc_value = 12'd1850;
        for (int n = 0; n < 12; n++) begin
            cycle();
            check_lit("hyst_exit_zone", zone, 32'd0);
            check_lit("hyst_exit_nopulse", {move_left, move_right}, 32'd0);
        end

        // Reversal mid-DAS while both buttons are pressed again
        btn_raw = 2'b00;
        cnt = 0;
        adc_value = 12'd2000;
        for (int n = 0; n < 4; n++) begin
            cycle();
            cnt += int'(combo_pulse);
        end
        adc_value = 12'd1000;
        for (int n = 0; n < 12; n++) begin
            cycle();
            obs = n + 1;
            cnt += int'(combo_pulse);
            check_lit("rev_left", move_left, (obs == 1 || obs == 11) ? 32'd1 : 32'd0);
            check_lit("rev_no_right", move_right, 32'd0);
            check_lit("rev_zone", zone, 32'd1);
        end
        adc_value = 12'd1600;
        for (int n = 0; n < 30; n++) begin
            cycle();
            cnt += int'(combo_pulse);
        end
        check_lit("combo_rearm_count", cnt, 32'd1);

        // Bounce on button 0, then settle pressed
        btn_raw = 2'b11;
        for (int n = 0; n < 10; n++) cycle();
        for (int n = 0; n < 36; n++) begin
            btn_raw[0] = (n < 20) ? (((n / 2) % 2 == 0) ? 1'b0 : 1'b1) : 1'b0;
            cycle();
            check_lit("bounce_press", btn_press[0], (n + 1 == 26) ? 32'd1 : 32'd0);
        end

        // Disabled with stick deflected and button 1 pressed; then re-enable
        enable = 1'b0;
        adc_value = 12'd2000;
        btn_raw = 2'b00;
        for (int n = 0; n < 8; n++) begin
            cycle();
            check_lit("dis_zone", zone, 32'd0);
            check_lit("dis_pulses", {btn_press, move_left, move_right, combo_pulse}, 32'd0);
        end
        enable = 1'b1;
        cycle();
        check_lit("reenable_pulse", {move_right, zone}, 32'd6);

        // Mid-operation reset aborts the repeat timer
        for (int n = 0; n < 12; n++) cycle();
        reset = 1'b1;
        cycle();
        check_lit("midreset_outputs", {btn_level, btn_press, move_left, move_right, zone, combo_pulse}, 32'd0);
        reset = 1'b0;
        adc_value = 12'd1600;
        for (int n = 0; n < 15; n++) begin
            cycle();
            check_lit("midreset_nopulse", {move_left, move_right}, 32'd0);
        end

        // Randomised phase
        for (int n = 0; n < 3000; n++) begin
            ch = int'($urandom_range(0, 7));
            if (ch == 0) begin
                case ($urandom_range(0, 11))
                    0: adc_value = 12'd1399;
                    1: adc_value = 12'd1400;
                    2: adc_value = 12'd1449;
                    3: adc_value = 12'd1450;
                    4: adc_value = 12'd1850;
                    5: adc_value = 12'd1851;
                    6: adc_value = 12'd1900;
                    7: adc_value = 12'd1901;
                    8: adc_value = 12'd0;
                    9: adc_value = 12'd4095;
                    default: adc_value = 12'($urandom_range(0, 4095));
                endcase
            end
            adc_valid = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 199) == 0) enable = ~enable;
            for (int i = 0; i < NB; i++) begin
                if ($urandom_range(0, ((n / 500) % 2 == 0) ? 9 : 39) == 0) btn_raw[i] = ~btn_raw[i];
            end
            reset = ($urandom_range(0, 399) == 0);
            cycle();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
